rhdma: RTL

DMA transfer sequencer for the RH11 disk/tape controller. It runs one block transfer between the controller's data FIFO and KS10 memory: it drives the bus address taken from the bus address register and pulses that register's increment strobe after each word. It also maintains the word count and reports completion or non-existent-memory (NXM) timeout to the RHCS1/RHCS2 status logic.

---
 rtl/rhdma.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rhdma.sv
// RH11 DMA transfer sequencer: moves one block between the controller data FIFO
// and KS10 memory, tracks the word count and flags NXM bus timeouts.
module rhdma #(
    parameter int TIMEOUT = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        rhCLR,
    input  logic        rhGO,
    input  logic        rhDIR,
    input  logic [15:0] rhWCINIT,
    input  logic [17:0] rhBA,
    output logic        rhINCBA,
    output logic        rhINCWC,
    output logic        rhBUSY,
    output logic        rhDONE,
    output logic        rhNXM,
    output logic        busREQ,
    output logic        busWRITE,
    output logic [17:0] busADDR,
    output logic [35:0] busDATAO,
    input  logic [35:0] busDATAI,
    input  logic        busACK,
    input  logic        fifoEMPTY,
    input  logic [35:0] fifoRDDATA,
    output logic        fifoRD,
    input  logic        fifoFULL,
    output logic        fifoWR,
    output logic [35:0] fifoWRDATA
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_REQ  = 3'd2,
        S_INC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Last REQ cycle index that may still wait for busACK.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_dir;
    logic        w_dir_nxt;
    logic [15:0] r_wc;
    logic [15:0] w_wc_nxt;
    logic [15:0] w_wc_inc;
    logic [35:0] r_data;
    logic [35:0] w_data_nxt;
    logic [7:0]  r_tmo;
    logic [7:0]  w_tmo_nxt;
    logic        w_nxm_nxt;
    logic        w_fifo_rd;
    logic        w_fifo_wr;
    logic [35:0] w_fifo_wrdata;
    logic        w_abort;

    assign w_abort  = devRESET | rhCLR;
    assign w_wc_inc = r_wc + 16'd1;
    assign busADDR  = (r_state == S_REQ) ? rhBA : 18'd0;

    // Next-state, datapath updates and strobe decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_dir_nxt     = r_dir;
        w_wc_nxt      = r_wc;
        w_data_nxt    = r_data;
        w_tmo_nxt     = r_tmo;
        w_nxm_nxt     = rhNXM;
        w_fifo_rd     = 1'b0;
        w_fifo_wr     = 1'b0;
        w_fifo_wrdata = fifoWRDATA;
        case (r_state)
            S_IDLE: begin
                if (rhGO) begin
                    w_dir_nxt   = rhDIR;
                    w_wc_nxt    = rhWCINIT;
                    w_nxm_nxt   = 1'b0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_dir && !fifoEMPTY) begin
                    w_fifo_rd   = 1'b1;
                    w_data_nxt  = fifoRDDATA;
                    w_tmo_nxt   = 8'd0;
                    w_state_nxt = S_REQ;
                end else if (!r_dir && !fifoFULL) begin
                    w_tmo_nxt   = 8'd0;
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_REQ: begin
                // An acknowledge on the final allowed cycle still wins over the timeout.
                if (busACK) begin
                    if (!r_dir) begin
                        w_fifo_wr     = 1'b1;
                        w_fifo_wrdata = busDATAI;
                    end else begin
                        w_fifo_wr     = 1'b0;
                    end
                    w_state_nxt = S_INC;
                end else if (r_tmo == TMO_LAST) begin
                    w_nxm_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_tmo_nxt   = r_tmo + 8'd1;
                end
            end
            S_INC: begin
                w_wc_nxt    = w_wc_inc;
                w_state_nxt = (w_wc_inc == 16'd0) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_nxm_nxt   = 1'b0;
            w_fifo_rd   = 1'b0;
            w_fifo_wr   = 1'b0;
        end else begin
            w_nxm_nxt   = w_nxm_nxt;
        end
    end

    // State, datapath and registered outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_wc       <= 16'd0;
            r_data     <= 36'd0;
            r_tmo      <= 8'd0;
            rhINCBA    <= 1'b0;
            rhINCWC    <= 1'b0;
            rhBUSY     <= 1'b0;
            rhDONE     <= 1'b0;
            rhNXM      <= 1'b0;
            busREQ     <= 1'b0;
            busWRITE   <= 1'b0;
            busDATAO   <= 36'd0;
            fifoRD     <= 1'b0;
            fifoWR     <= 1'b0;
            fifoWRDATA <= 36'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_wc       <= w_wc_nxt;
            r_data     <= w_data_nxt;
            r_tmo      <= w_tmo_nxt;
            rhINCBA    <= (w_state_nxt == S_INC);
            rhINCWC    <= (w_state_nxt == S_INC);
            rhBUSY     <= (w_state_nxt != S_IDLE);
            rhDONE     <= (w_state_nxt == S_DONE);
            rhNXM      <= w_nxm_nxt;
            busREQ     <= (w_state_nxt == S_REQ);
            busWRITE   <= (w_state_nxt == S_REQ) && w_dir_nxt;
            busDATAO   <= ((w_state_nxt == S_REQ) && w_dir_nxt) ? w_data_nxt : 36'd0;
            fifoRD     <= w_fifo_rd;
            fifoWR     <= w_fifo_wr;
            fifoWRDATA <= w_fifo_wrdata;
        end
    end

endmodule
